// File: rtl/qea_host_sequencer_if.sv
// Stream bundle between the host sequencer and its environment.
//   s_ctx_*   : context-word stream into the sequencer (valid/ready/data)
//   m_state_* : state-word readout stream out of the sequencer (valid/ready/data)
// Modports: slave = sequencer side, master = host/environment side.
interface qea_host_sequencer_if #(
  parameter int unsigned PE_NUM     = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                               s_ctx_valid;
  logic                               s_ctx_ready;
  logic [2*DATA_WIDTH-1:0]            s_ctx_data;
  logic                               m_state_valid;
  logic                               m_state_ready;
  logic [PE_NUM*2*DATA_WIDTH-1:0]     m_state_data;

  modport master (
    output s_ctx_valid, s_ctx_data, m_state_ready,
    input  s_ctx_ready, m_state_valid, m_state_data
  );

  modport slave (
    input  s_ctx_valid, s_ctx_data, m_state_ready,
    output s_ctx_ready, m_state_valid, m_state_data
  );
endinterface

// File: rtl/qea_host_sequencer.sv
// Host-side run sequencer for the QEA core: loads gate context words into the
// context RAM, initialises the state vector to |0...0>, starts the core, waits
// for completion and streams every state word back out.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_go, i_qbit_num, i_ins_num  run request and its latched arguments
//   bus (slave)                  context input stream and state readout stream
//   o_start, o_qbit_num          core start pulse and latched qubit count
//   o_ctx_*                      context RAM write port
//   o_state_*, i_state_dout      state RAM port (write during init, read at readout)
//   i_complete                   core completion level
//   o_busy, o_done, o_err        status
module qea_host_sequencer #(
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned RD_LAT                  = 1,
  parameter int unsigned NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  qea_host_sequencer_if.slave                  bus,
  output logic                                 o_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [2*DATA_WIDTH-1:0]              o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_state_dina,
  input  logic                                 i_complete,
  input  logic [PE_NUM*2*DATA_WIDTH-1:0]       i_state_dout,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err
);
  localparam int unsigned SW = PE_NUM * 2 * DATA_WIDTH;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StLoadCtx = 4'd1;
  localparam logic [3:0] StInit    = 4'd2;
  localparam logic [3:0] StStart   = 4'd3;
  localparam logic [3:0] StWait    = 4'd4;
  localparam logic [3:0] StRdReq   = 4'd5;
  localparam logic [3:0] StRdWait  = 4'd6;
  localparam logic [3:0] StRdHold  = 4'd7;
  localparam logic [3:0] StDone    = 4'd8;

  localparam logic [MAX_QBIT_WIDTH-1:0] QbitMin = MAX_QBIT_WIDTH'(2);
  localparam logic [MAX_QBIT_WIDTH-1:0] QbitMax = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2);
  localparam logic [2:0]                LatLast = 3'(RD_LAT - 1);
  localparam logic [DATA_WIDTH-1:0]     AmpOne  = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  // |0...0>: real part of the most significant lane of word 0 is 1.0
  localparam logic [SW-1:0]             InitWord = {AmpOne, {(SW - DATA_WIDTH){1'b0}}};

  logic [3:0]                           state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0]            qbit_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_cnt_q;
  logic [STATE_ADDR_WIDTH-1:0]          st_cnt_q;
  logic [2:0]                           lat_q;
  logic                                 skip_q;
  logic                                 err_q;
  logic                                 err_done_q;
  logic                                 ctx_en_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_q;
  logic [2*DATA_WIDTH-1:0]              ctx_data_q;
  logic [SW-1:0]                        rd_data_q;

  logic                                 go_bad;
  logic                                 ctx_fire;
  logic [STATE_ADDR_WIDTH:0]            n_words;
  logic [STATE_ADDR_WIDTH-1:0]          last_st;

  assign go_bad   = (i_qbit_num < QbitMin) || (i_qbit_num > QbitMax) || (i_ins_num == '0);
  assign ctx_fire = bus.s_ctx_valid && bus.s_ctx_ready;
  // One extra bit so qbit = STATE_ADDR_WIDTH+2 (full RAM) does not overflow before the -1
  assign n_words  = (STATE_ADDR_WIDTH + 1)'(1) << (qbit_q - QbitMin);
  assign last_st  = STATE_ADDR_WIDTH'(n_words - 1'b1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (i_go && !go_bad) state_d = StLoadCtx;
      StLoadCtx: if (ctx_fire && (ctx_cnt_q == ins_q - 1'b1)) state_d = StInit;
      StInit:    if (st_cnt_q == last_st) state_d = StStart;
      StStart:   state_d = StWait;
      StWait:    if (!skip_q && i_complete) state_d = StRdReq;
      StRdReq:   state_d = StRdWait;
      StRdWait:  if (lat_q == LatLast) state_d = StRdHold;
      StRdHold:  if (bus.m_state_ready) state_d = (st_cnt_q == last_st) ? StDone : StRdReq;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      qbit_q     <= '0;
      ins_q      <= '0;
      ctx_cnt_q  <= '0;
      st_cnt_q   <= '0;
      lat_q      <= '0;
      skip_q     <= 1'b0;
      err_q      <= 1'b0;
      err_done_q <= 1'b0;
      ctx_en_q   <= 1'b0;
      ctx_addr_q <= '0;
      ctx_data_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ctx_en_q   <= 1'b0;
      err_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_go) begin
            qbit_q     <= i_qbit_num;
            ins_q      <= i_ins_num;
            err_q      <= go_bad;
            err_done_q <= go_bad;
            ctx_cnt_q  <= '0;
            st_cnt_q   <= '0;
          end
        end
        StLoadCtx: begin
          if (ctx_fire) begin
            ctx_en_q   <= 1'b1;
            ctx_addr_q <= ctx_cnt_q;
            ctx_data_q <= bus.s_ctx_data;
            // Hold at the terminal count instead of wrapping
            if (state_d == StLoadCtx) ctx_cnt_q <= ctx_cnt_q + 1'b1;
          end
        end
        StInit:   st_cnt_q <= (state_d == StInit) ? st_cnt_q + 1'b1 : '0;
        StStart:  skip_q <= 1'b1;
        StWait:   skip_q <= 1'b0;
        StRdReq:  lat_q <= '0;
        StRdWait: begin
          lat_q <= lat_q + 1'b1;
          if (lat_q == LatLast) rd_data_q <= i_state_dout;
        end
        StRdHold: if (bus.m_state_ready && (state_d == StRdReq)) st_cnt_q <= st_cnt_q + 1'b1;
        StDone: begin
          err_q    <= 1'b0;
          st_cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ctx_ready   = (state_q == StLoadCtx);
  assign bus.m_state_valid = (state_q == StRdHold);
  assign bus.m_state_data  = rd_data_q;

  assign o_start       = (state_q == StStart);
  assign o_qbit_num    = qbit_q;
  assign o_ctx_en      = ctx_en_q;
  assign o_ctx_wea     = ctx_en_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = (state_q == StInit) || (state_q == StRdReq);
  assign o_state_wea   = (state_q == StInit);
  assign o_state_addra = st_cnt_q;
  assign o_state_dina  = ((state_q == StInit) && (st_cnt_q == '0)) ? InitWord : '0;
  assign o_busy        = (state_q != StIdle);
  assign o_done        = err_done_q || (state_q == StDone);
  assign o_err         = err_q;
endmodule

// File: tb/tb_qea_host_sequencer.sv
module tb_qea_host_sequencer;
  localparam int unsigned PE  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned SAW = 16;
  localparam int unsigned GAW = 16;
  localparam int unsigned QW  = 6;
  localparam int unsigned RDL = 2;
  localparam int unsigned SW  = PE * 2 * DW;
  localparam int unsigned CW  = 2 * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_go;
  logic [QW-1:0]   i_qbit_num;
  logic [GAW-1:0]  i_ins_num;
  logic            o_start;
  logic [QW-1:0]   o_qbit_num;
  logic            o_ctx_en, o_ctx_wea;
  logic [GAW-1:0]  o_ctx_addr;
  logic [CW-1:0]   o_ctx_data;
  logic            o_state_ena, o_state_wea;
  logic [SAW-1:0]  o_state_addra;
  logic [SW-1:0]   o_state_dina;
  logic            i_complete;
  logic [SW-1:0]   i_state_dout;
  logic            o_busy, o_done, o_err;

  qea_host_sequencer_if #(.PE_NUM(PE), .DATA_WIDTH(DW)) bus ();

  qea_host_sequencer #(
    .PE_NUM(PE), .DATA_WIDTH(DW), .STATE_ADDR_WIDTH(SAW), .GATE_CONTEXT_ADDR_WIDTH(GAW),
    .MAX_QBIT_WIDTH(QW), .RD_LAT(RDL), .NUM_FRAC_BIT(30)
  ) dut (
    .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .bus(bus), .o_start(o_start), .o_qbit_num(o_qbit_num), .o_ctx_en(o_ctx_en),
    .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .i_complete(i_complete), .i_state_dout(i_state_dout),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observation log, filled on the falling edge.
  int            cyc = 0;
  int            start_cnt, start_cyc, first_rd_cyc, done_cnt, en_cnt, stall_viol;
  bit            hold_prev, ctx_acc;
  logic [SW-1:0] prev_data;
  logic [GAW-1:0] ctx_addr_q[$];
  logic [CW-1:0]  ctx_data_q[$];
  logic [CW-1:0]  sent_q[$];
  logic [SAW-1:0] st_waddr_q[$];
  logic [SW-1:0]  st_wdata_q[$];
  logic [SW-1:0]  out_q[$];

  // State RAM plus a stand-in core that rewrites every word when started.
  logic [SW-1:0] mem [16];
  logic [SW-1:0] exp_mem [16];
  logic [SW-1:0] pipe [RDL];

  always @(posedge clk) begin : ram_model
    logic [SW-1:0] w;
    if (o_start) begin
      for (int a = 0; a < 16; a++) begin
        for (int j = 0; j < SW / 32; j++) w[j*32 +: 32] = $urandom;
        exp_mem[a] = w;
        mem[a] <= w;
      end
    end else if (o_state_ena && o_state_wea) begin
      mem[o_state_addra[3:0]] <= o_state_dina;
    end
    if (o_state_ena && !o_state_wea) pipe[0] <= mem[o_state_addra[3:0]];
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign i_state_dout = pipe[RDL-1];

  always @(negedge clk) begin
    cyc++;
    if (o_ctx_en && o_ctx_wea) begin
      ctx_addr_q.push_back(o_ctx_addr);
      ctx_data_q.push_back(o_ctx_data);
    end
    if (o_state_ena && o_state_wea) begin
      st_waddr_q.push_back(o_state_addra);
      st_wdata_q.push_back(o_state_dina);
    end
    if (o_state_ena && !o_state_wea && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (o_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (o_done) done_cnt++;
    if (o_ctx_en || o_state_ena) en_cnt++;
    if (bus.m_state_valid) begin
      if (hold_prev && bus.m_state_data !== prev_data) stall_viol++;
      if (bus.m_state_ready) begin
        out_q.push_back(bus.m_state_data);
        hold_prev = 1'b0;
      end else begin
        hold_prev = 1'b1;
        prev_data = bus.m_state_data;
      end
    end else begin
      hold_prev = 1'b0;
    end
    ctx_acc = (bus.s_ctx_valid === 1'b1) && (bus.s_ctx_ready === 1'b1);
  end

  task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    start_cnt = 0; start_cyc = 0; first_rd_cyc = -1; done_cnt = 0; en_cnt = 0;
    stall_viol = 0; hold_prev = 1'b0; ctx_acc = 1'b0;
    ctx_addr_q.delete(); ctx_data_q.delete(); sent_q.delete();
    st_waddr_q.delete(); st_wdata_q.delete(); out_q.delete();
  endtask

  // Drives one run cycle by cycle until o_done is seen (bounded), or until
  // abort_at state writes have been seen, where rst is raised mid-cycle.
  task automatic run_job(input int q, input int ins, input bit gapped, input bit cmpl_early,
                         input bit go_mid, input int abort_at);
    logic [CW-1:0] cur;
    clear_logs();
    cur = {$urandom, $urandom};
    @(posedge clk); #1;
    i_qbit_num = QW'(q);
    i_ins_num  = GAW'(ins);
    i_go       = 1'b1;
    i_complete = cmpl_early;
    @(posedge clk); #1;
    i_go = 1'b0;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      if (ctx_acc) begin
        sent_q.push_back(cur);
        cur = {$urandom, $urandom};
      end
      bus.s_ctx_valid   = gapped ? (k % 3 == 0) : 1'b1;
      bus.s_ctx_data    = cur;
      bus.m_state_ready = 1'($urandom_range(0, 1));
      if (!cmpl_early) i_complete = (start_cnt > 0) && (cyc - start_cyc >= 3);
      if (go_mid) begin
        i_go       = (k == 10);
        i_qbit_num = (k == 10) ? QW'(7) : QW'(q);
      end
      if (abort_at > 0 && st_waddr_q.size() >= abort_at) begin
        #2 rst = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    bus.s_ctx_valid   = 1'b0;
    bus.m_state_ready = 1'b0;
    i_complete        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_job(input int q, input int ins);
    int n;
    int bad;
    logic [SW-1:0] init_exp;
    n = 1 << (q - 2);
    init_exp = '0;
    init_exp[SW-1 -: DW] = 32'h4000_0000;
    chk("ctx_write_count", SW'(ctx_addr_q.size()), SW'(ins));
    chk("ctx_beats_sent", SW'(sent_q.size()), SW'(ins));
    bad = 0;
    for (int i = 0; i < ctx_addr_q.size(); i++)
      if (ctx_addr_q[i] !== GAW'(i) || i >= sent_q.size() || ctx_data_q[i] !== sent_q[i]) bad++;
    chk("ctx_seq_errors", SW'(bad), '0);
    chk("state_write_count", SW'(st_waddr_q.size()), SW'(n));
    if (st_wdata_q.size() > 0) chk("init_word0", st_wdata_q[0], init_exp);
    bad = 0;
    for (int i = 0; i < st_waddr_q.size(); i++)
      if (st_waddr_q[i] !== SAW'(i) || st_wdata_q[i] !== ((i == 0) ? init_exp : '0)) bad++;
    chk("init_errors", SW'(bad), '0);
    chk("start_count", SW'(start_cnt), SW'(1));
    chk("rd_after_start_ge2", SW'(first_rd_cyc - start_cyc >= 2), SW'(1));
    chk("readout_count", SW'(out_q.size()), SW'(n));
    bad = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== exp_mem[i]) bad++;
    chk("readout_errors", SW'(bad), '0);
    chk("stall_stable", SW'(stall_viol), '0);
    chk("done_count", SW'(done_cnt), SW'(1));
    chk("err_clear", SW'(o_err), '0);
    chk("busy_idle", SW'(o_busy), '0);
    chk("qbit_latched", SW'(o_qbit_num), SW'(q));
  endtask

  function automatic logic any_out();
    return |{o_start, o_qbit_num, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data, o_state_ena,
             o_state_wea, o_state_addra, o_state_dina, bus.s_ctx_ready, bus.m_state_valid,
             bus.m_state_data, o_busy, o_done, o_err};
  endfunction

  initial begin
    int ins;
    rst = 1'b1; i_go = 1'b0; i_qbit_num = '0; i_ins_num = '0; i_complete = 1'b0;
    bus.s_ctx_valid = 1'b0; bus.s_ctx_data = '0; bus.m_state_ready = 1'b0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", SW'(any_out()), '0);
    rst = 1'b0;

    // Rejected requests
    run_job(1, 5, 1'b0, 1'b0, 1'b0, 0);
    chk("q1_err", SW'(o_err), SW'(1));
    chk("q1_done_pulse", SW'(done_cnt), SW'(1));
    chk("q1_no_ram_en", SW'(en_cnt), '0);
    chk("q1_busy", SW'(o_busy), '0);
    run_job(19, 5, 1'b0, 1'b0, 1'b0, 0);
    chk("q19_err", SW'(o_err), SW'(1));
    chk("q19_no_ram_en", SW'(en_cnt), '0);
    run_job(3, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("ins0_err", SW'(o_err), SW'(1));
    chk("ins0_done_pulse", SW'(done_cnt), SW'(1));

    // qbit=3, 81 context words, ctx always valid
    run_job(3, 81, 1'b0, 1'b0, 1'b0, 0);
    check_job(3, 81);

    // Gapped ctx, completion held high before start, stray go while busy
    ins = $urandom_range(5, 20);
    run_job(4, ins, 1'b1, 1'b1, 1'b1, 0);
    check_job(4, ins);

    // Single-word state vector
    ins = $urandom_range(1, 4);
    run_job(2, ins, 1'b0, 1'b0, 1'b0, 0);
    check_job(2, ins);

    // Reset during INIT aborts the run
    run_job(5, 3, 1'b0, 1'b0, 1'b0, 3);
    #1;
    chk("abort_outputs_zero", SW'(any_out()), '0);
    bus.s_ctx_valid = 1'b0; bus.m_state_ready = 1'b0; i_complete = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", SW'(done_cnt), '0);
    chk("abort_idle", SW'(o_busy), '0);

    // Normal run after the abort
    run_job(3, 7, 1'b0, 1'b0, 1'b0, 0);
    check_job(3, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
